// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, an optional
// two-entry skid buffer, a stall (WE_n) and a flush (CLR). The head entry
// always comes from the main register. Control bits read as zero whenever
// the stage presents a bubble.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 96,
    parameter int unsigned CTRL_W   = 40,
    parameter int unsigned SKID     = 1,
    parameter int unsigned CLR_DATA = 0
) (
    input  logic              i_Clk,
    input  logic              Reset,
    input  logic              WE_n,
    input  logic              CLR,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [DATA_W-1:0] i_Data,
    input  logic [CTRL_W-1:0] i_Ctrl,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [DATA_W-1:0] o_Data,
    output logic [CTRL_W-1:0] o_Ctrl,
    output logic [1:0]        o_Count
);

    // State encoding equals the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

    logic                full;
    logic                fin;
    logic                fout;

    // Handshake outputs; a stall hides the entry and blocks intake.
    always_comb begin
        full    = (state_q != StEmpty);
        o_Valid = full & ~WE_n;
        if (SKID != 0) begin
            o_Ready = ready_q & ~WE_n;
        end else begin
            o_Ready = (~full | i_Ready) & ~WE_n;
        end
        o_Data  = main_data_q;
        o_Ctrl  = main_ctrl_q & {CTRL_W{o_Valid}};
        o_Count = state_q;
        fin     = i_Valid & o_Ready;
        fout    = o_Valid & i_Ready;
    end

    // Next-state: flush first, then transfers (a stall already forces fin = fout = 0).
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (CLR) begin
            state_d     = StEmpty;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLR_DATA != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else if (SKID != 0) begin
            unique case (state_q)
                StEmpty: begin
                    if (fin) begin
                        main_data_d = i_Data;
                        main_ctrl_d = i_Ctrl;
                        state_d     = StOne;
                    end
                end
                StOne: begin
                    if (fin && fout) begin
                        main_data_d = i_Data;
                        main_ctrl_d = i_Ctrl;
                    end else if (fin) begin
                        skid_data_d = i_Data;
                        skid_ctrl_d = i_Ctrl;
                        state_d     = StTwo;
                    end else if (fout) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // Intake is closed in this state, only the head can leave.
                    if (fout) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end else begin
            if (fin) begin
                main_data_d = i_Data;
                main_ctrl_d = i_Ctrl;
                state_d     = StOne;
            end else if (fout) begin
                state_d = StEmpty;
            end
        end

        // Registered ready so the skid variant has no i_Ready -> o_Ready path.
        ready_d = (state_d != StTwo);
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (Reset) begin
            state_q     <= StEmpty;
            ready_q     <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1/CLR_DATA=0 instance (a_*) and a
// SKID=0/CLR_DATA=1 instance (b_*), each tracked by a FIFO-queue model.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_rst, a_we_n, a_clr, a_ivalid, a_iready, a_oready, a_ovalid;
    logic [DW-1:0] a_idata, a_odata;
    logic [CW-1:0] a_ictrl, a_octrl;
    logic [1:0]    a_ocount;
    logic          b_rst, b_we_n, b_clr, b_ivalid, b_iready, b_oready, b_ovalid;
    logic [DW-1:0] b_idata, b_odata;
    logic [CW-1:0] b_ictrl, b_octrl;
    logic [1:0]    b_ocount;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLR_DATA(0)) dut_a (
        .i_Clk(clk), .Reset(a_rst), .WE_n(a_we_n), .CLR(a_clr),
        .i_Valid(a_ivalid), .o_Ready(a_oready), .i_Data(a_idata), .i_Ctrl(a_ictrl),
        .o_Valid(a_ovalid), .i_Ready(a_iready), .o_Data(a_odata), .o_Ctrl(a_octrl),
        .o_Count(a_ocount)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CLR_DATA(1)) dut_b (
        .i_Clk(clk), .Reset(b_rst), .WE_n(b_we_n), .CLR(b_clr),
        .i_Valid(b_ivalid), .o_Ready(b_oready), .i_Data(b_idata), .i_Ctrl(b_ictrl),
        .o_Valid(b_ovalid), .i_Ready(b_iready), .o_Data(b_odata), .o_Ctrl(b_octrl),
        .o_Count(b_ocount)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    // Model: ordered FIFO of accepted entries plus the last head shown.
    ent_t          qa[$];
    ent_t          qb[$];
    logic [DW-1:0] a_last = '0;
    logic [DW-1:0] b_last = '0;

    function automatic bit ea_valid();
        return !a_we_n && qa.size() > 0;
    endfunction
    function automatic bit ea_ready();
        return !a_we_n && qa.size() < 2;
    endfunction
    function automatic logic [CW-1:0] ea_ctrl();
        return ea_valid() ? qa[0].c : '0;
    endfunction
    function automatic logic [DW-1:0] ea_data();
        return qa.size() > 0 ? qa[0].d : a_last;
    endfunction
    function automatic bit eb_valid();
        return !b_we_n && qb.size() > 0;
    endfunction
    function automatic bit eb_ready();
        return !b_we_n && (qb.size() == 0 || b_iready);
    endfunction
    function automatic logic [CW-1:0] eb_ctrl();
        return eb_valid() ? qb[0].c : '0;
    endfunction
    function automatic logic [DW-1:0] eb_data();
        return qb.size() > 0 ? qb[0].d : b_last;
    endfunction

    // One clock: decide transfers from the model, take the edge, update the model.
    task automatic tick();
        bit   fin_a, fout_a, fin_b, fout_b;
        ent_t e;
        fin_a  = a_ivalid && ea_ready();
        fout_a = ea_valid() && a_iready;
        fin_b  = b_ivalid && eb_ready();
        fout_b = eb_valid() && b_iready;
        @(posedge clk);
        if (a_rst) begin
            qa.delete();
            a_last = '0;
        end else if (a_clr) begin
            qa.delete();
        end else begin
            if (fout_a) void'(qa.pop_front());
            if (fin_a) begin
                e.d = a_idata; e.c = a_ictrl; qa.push_back(e);
            end
        end
        if (qa.size() > 0) a_last = qa[0].d;
        if (b_rst || b_clr) begin
            qb.delete();
            b_last = '0;
        end else begin
            if (fout_b) void'(qb.pop_front());
            if (fin_b) begin
                e.d = b_idata; e.c = b_ictrl; qb.push_back(e);
            end
        end
        if (qb.size() > 0) b_last = qb[0].d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        a_rst = 1; b_rst = 1; a_ivalid = 1; b_ivalid = 1;
        a_ictrl = 'hFF; b_ictrl = 'hFF; a_idata = 'h1234; b_idata = 'h1234;
        tick(); tick();
        #1;
        total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", a_ovalid); end
        total++; if (a_octrl !== '0) begin bad++; $display("FAIL reset_ctrl got=%0h want=0", a_octrl); end
        total++; if (a_odata !== '0) begin bad++; $display("FAIL reset_data got=%0h want=0", a_odata); end
        total++; if (a_ocount !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", a_ocount); end
        total++; if (b_ocount !== 2'd0) begin bad++; $display("FAIL reset_count_b got=%0d want=0", b_ocount); end
        total++; if (b_odata !== '0) begin bad++; $display("FAIL reset_data_b got=%0h want=0", b_odata); end
        a_rst = 0; b_rst = 0; a_ivalid = 0; b_ivalid = 0;
        #1;
        total++; if (a_oready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h want=1", a_oready); end
        total++; if (b_oready !== 1'b1) begin bad++; $display("FAIL reset_ready_b got=%0h want=1", b_oready); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals [3];
        vals[0] = 'h11; vals[1] = 'h22; vals[2] = 'h33;
        a_iready = 1;
        for (int i = 0; i < 4; i++) begin
            a_ivalid = (i < 3);
            a_idata  = (i < 3) ? vals[i] : '0;
            a_ictrl  = CW'(i + 1);
            #1;
            if (i > 0) begin
                total++; if (a_odata !== vals[i-1]) begin bad++; $display("FAIL stream_data got=%0h want=%0h", a_odata, vals[i-1]); end
                total++; if (a_octrl !== CW'(i)) begin bad++; $display("FAIL stream_ctrl got=%0h want=%0h", a_octrl, i); end
                total++; if (a_ovalid !== 1'b1) begin bad++; $display("FAIL stream_valid got=%0h want=1", a_ovalid); end
                total++; if (a_ocount !== 2'd1) begin bad++; $display("FAIL stream_count got=%0d want=1", a_ocount); end
            end
            tick();
        end
        #1;
        total++; if (a_ocount !== 2'd0 || a_ovalid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0d/%0h want=0/0", a_ocount, a_ovalid); end
        a_iready = 0;
    endtask

    task automatic test_skid_fill();
        a_iready = 0; a_ivalid = 1; a_idata = 'hA1; a_ictrl = 'h1;
        #1;
        total++; if (a_oready !== 1'b1) begin bad++; $display("FAIL fill_ready0 got=%0h want=1", a_oready); end
        tick();
        a_idata = 'hA2; a_ictrl = 'h2;
        #1;
        total++; if (a_oready !== 1'b1 || a_ocount !== 2'd1) begin bad++; $display("FAIL fill_one got=%0h/%0d want=1/1", a_oready, a_ocount); end
        tick();
        a_ivalid = 0;
        #1;
        total++; if (a_ocount !== 2'd2) begin bad++; $display("FAIL fill_count2 got=%0d want=2", a_ocount); end
        total++; if (a_oready !== 1'b0) begin bad++; $display("FAIL fill_ready2 got=%0h want=0", a_oready); end
        total++; if (a_odata !== 'hA1) begin bad++; $display("FAIL fill_head got=%0h want=a1", a_odata); end
        a_iready = 1;
        #1;
        tick();
        #1;
        total++; if (a_ocount !== 2'd1 || a_odata !== 'hA2) begin bad++; $display("FAIL fill_pop1 got=%0d/%0h want=1/a2", a_ocount, a_odata); end
        total++; if (a_octrl !== 'h2) begin bad++; $display("FAIL fill_pop1_ctrl got=%0h want=2", a_octrl); end
        tick();
        #1;
        total++; if (a_ocount !== 2'd0 || a_ovalid !== 1'b0) begin bad++; $display("FAIL fill_pop2 got=%0d/%0h want=0/0", a_ocount, a_ovalid); end
        a_iready = 0;
    endtask

    task automatic test_clr_in_two();
        a_iready = 0; a_ivalid = 1; a_idata = 'hB1; a_ictrl = 'h5;
        tick();
        a_idata = 'hB2;
        tick();
        #1;
        total++; if (a_ocount !== 2'd2) begin bad++; $display("FAIL clr_pre_count got=%0d want=2", a_ocount); end
        a_clr = 1; a_we_n = 1; a_ivalid = 1; a_idata = 'hCC; a_ictrl = 'h7;
        tick();
        a_clr = 0; a_we_n = 0; a_ivalid = 0;
        #1;
        total++; if (a_ocount !== 2'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", a_ocount); end
        total++; if (a_ovalid !== 1'b0 || a_octrl !== '0) begin bad++; $display("FAIL clr_bubble got=%0h/%0h want=0/0", a_ovalid, a_octrl); end
        total++; if (a_oready !== 1'b1) begin bad++; $display("FAIL clr_ready got=%0h want=1", a_oready); end
        total++; if (a_odata !== 'hB1) begin bad++; $display("FAIL clr_data_hold got=%0h want=b1", a_odata); end
    endtask

    task automatic test_stall();
        a_iready = 0; a_ivalid = 1; a_idata = 'h5A; a_ictrl = 'h3;
        tick();
        a_we_n = 1; a_idata = 'h99; a_ictrl = 'h9;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (a_ovalid !== 1'b0 || a_octrl !== '0) begin bad++; $display("FAIL stall_hidden got=%0h/%0h want=0/0", a_ovalid, a_octrl); end
            total++; if (a_oready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%0h want=0", a_oready); end
            total++; if (a_odata !== 'h5A || a_ocount !== 2'd1) begin bad++; $display("FAIL stall_hold got=%0h/%0d want=5a/1", a_odata, a_ocount); end
            tick();
        end
        a_we_n = 0; a_ivalid = 0; a_iready = 1;
        #1;
        total++; if (a_odata !== 'h5A || a_octrl !== 'h3 || a_ovalid !== 1'b1) begin bad++; $display("FAIL stall_resume got=%0h/%0h/%0h want=5a/3/1", a_odata, a_octrl, a_ovalid); end
        tick();
        #1;
        total++; if (a_ocount !== 2'd0) begin bad++; $display("FAIL stall_drain got=%0d want=0", a_ocount); end
        a_iready = 0;
    endtask

    task automatic test_skid0_stream();
        int sent = 0;
        int recv = 0;
        b_we_n = 0; b_clr = 0;
        for (int i = 0; i < 30; i++) begin
            b_iready = (i % 3 != 1);
            b_ivalid = (i < 24);
            b_idata  = DW'(sent + 'h100);
            b_ictrl  = CW'(sent + 1);
            #1;
            total++; if (b_oready !== ((qb.size() == 0) || b_iready)) begin bad++; $display("FAIL s0_ready got=%0h want=%0h", b_oready, (qb.size() == 0) || b_iready); end
            total++; if (b_ovalid !== (qb.size() > 0)) begin bad++; $display("FAIL s0_valid got=%0h want=%0h", b_ovalid, qb.size() > 0); end
            if (qb.size() > 0 && b_iready) begin
                total++; if (b_odata !== DW'(recv + 'h100) || b_octrl !== CW'(recv + 1)) begin bad++; $display("FAIL s0_order got=%0h/%0h want=%0h/%0h", b_odata, b_octrl, recv + 'h100, recv + 1); end
                recv++;
            end
            if (b_ivalid && eb_ready()) sent++;
            tick();
        end
        #1;
        total++; if (b_ocount !== 2'd0 || recv != sent) begin bad++; $display("FAIL s0_complete got=%0d/%0d want=0/%0d", b_ocount, recv, sent); end
    endtask

    task automatic test_random_a();
        for (int i = 0; i < 400; i++) begin
            a_rst    = ($urandom_range(0, 99) == 0);
            a_clr    = ($urandom_range(0, 39) == 0);
            a_we_n   = ($urandom_range(0, 7) == 0);
            a_ivalid = 1'($urandom_range(0, 1));
            a_iready = ($urandom_range(0, 2) != 0);
            a_idata  = DW'({$urandom, $urandom, $urandom});
            a_ictrl  = CW'({$urandom, $urandom});
            #1;
            total++; if (a_ovalid !== ea_valid()) begin bad++; $display("FAIL rnd_a_valid got=%0h want=%0h", a_ovalid, ea_valid()); end
            total++; if (a_oready !== ea_ready()) begin bad++; $display("FAIL rnd_a_ready got=%0h want=%0h", a_oready, ea_ready()); end
            total++; if (a_ocount !== 2'(qa.size())) begin bad++; $display("FAIL rnd_a_count got=%0d want=%0d", a_ocount, qa.size()); end
            total++; if (a_octrl !== ea_ctrl()) begin bad++; $display("FAIL rnd_a_ctrl got=%0h want=%0h", a_octrl, ea_ctrl()); end
            total++; if (a_odata !== ea_data()) begin bad++; $display("FAIL rnd_a_data got=%0h want=%0h", a_odata, ea_data()); end
            tick();
        end
        a_rst = 0; a_clr = 0; a_we_n = 0; a_ivalid = 0; a_iready = 0;
    endtask

    task automatic test_random_b();
        for (int i = 0; i < 300; i++) begin
            b_rst    = ($urandom_range(0, 99) == 0);
            b_clr    = ($urandom_range(0, 29) == 0);
            b_we_n   = ($urandom_range(0, 7) == 0);
            b_ivalid = 1'($urandom_range(0, 1));
            b_iready = 1'($urandom_range(0, 1));
            b_idata  = DW'({$urandom, $urandom, $urandom});
            b_ictrl  = CW'({$urandom, $urandom});
            #1;
            total++; if (b_ovalid !== eb_valid()) begin bad++; $display("FAIL rnd_b_valid got=%0h want=%0h", b_ovalid, eb_valid()); end
            total++; if (b_oready !== eb_ready()) begin bad++; $display("FAIL rnd_b_ready got=%0h want=%0h", b_oready, eb_ready()); end
            total++; if (b_ocount !== 2'(qb.size())) begin bad++; $display("FAIL rnd_b_count got=%0d want=%0d", b_ocount, qb.size()); end
            total++; if (b_octrl !== eb_ctrl()) begin bad++; $display("FAIL rnd_b_ctrl got=%0h want=%0h", b_octrl, eb_ctrl()); end
            total++; if (b_odata !== eb_data()) begin bad++; $display("FAIL rnd_b_data got=%0h want=%0h", b_odata, eb_data()); end
            tick();
        end
        b_rst = 0; b_clr = 0; b_we_n = 0; b_ivalid = 0; b_iready = 0;
    endtask

    initial begin
        a_rst = 1; a_we_n = 0; a_clr = 0; a_ivalid = 0; a_iready = 0; a_idata = '0; a_ictrl = '0;
        b_rst = 1; b_we_n = 0; b_clr = 0; b_ivalid = 0; b_iready = 0; b_idata = '0; b_ictrl = '0;
        test_reset();
        test_stream();
        test_skid_fill();
        test_clr_in_two();
        test_stall();
        test_skid0_stream();
        test_random_a();
        test_random_b();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the MIPS core. It replaces the fixed-field stage registers with one block that carries a data bundle and a control bundle.
- Adds a valid/ready handshake, an optional two-entry skid buffer, stall (WE_n) and flush (CLR).
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB. Each instance is sized by parameters.

Parameters:
- DATA_W, 96: width of the data bundle (e.g. RD1, RD2, SignImm).
- CTRL_W, 40: width of the control bundle (e.g. ALUSrc, RegDst, RegWrite, MemWrite, MemtoReg, ALUCtrl, PCImm). These bits are forced to zero whenever the stage holds a bubble.
- SKID, 1: 1 gives two entries (main + skid) with a registered o_Ready; 0 gives one entry with o_Ready = ~full | i_Ready.
- CLR_DATA, 0: 1 zeroes the data registers on CLR/Reset; 0 zeroes only the control and valid state on CLR.

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- WE_n  in  1  active-low stage enable; 1 = stall/freeze.
- CLR  in  1  synchronous flush; empties the stage.
- i_Valid  in  1  upstream entry valid.
- o_Ready  out  1  stage can accept an entry this cycle.
- i_Data  in  DATA_W  upstream data bundle.
- i_Ctrl  in  CTRL_W  upstream control bundle.
- o_Valid  out  1  stage presents a valid entry.
- i_Ready  in  1  downstream accepts this cycle.
- o_Data  out  DATA_W  head data.
- o_Ctrl  out  CTRL_W  head control; 0 when o_Valid=0.
- o_Count  out  2  occupancy, 0..2 (0..1 when SKID=0).

Behaviour:
- Transfers:
  - Upstream fire (fin) = i_Valid & o_Ready.
  - Downstream fire (fout) = o_Valid & i_Ready.
- Priority per edge: Reset > CLR > WE_n stall > normal transfers.
- Reset:
  - State goes to EMPTY; o_Count=0 and o_Valid=0.
  - o_Ctrl=0 and o_Data=0 the cycle after, regardless of CLR_DATA.
  - o_Ready=1 in the cycle after Reset deasserts.
- CLR=1 (WE_n ignored):
  - Next state is EMPTY, control registers are 0, and both entries are discarded.
  - fin in the same cycle is dropped. Upstream must treat it as killed.
  - Data registers are zeroed if CLR_DATA=1, otherwise they hold.
- WE_n=1 (and no CLR):
  - All registers hold.
  - o_Ready=0 and o_Valid=0 combinationally, so no fin and no fout can occur.
  - o_Data holds its value; o_Ctrl reads 0.
- State machine for SKID=1. States are EMPTY, ONE, TWO, each equal to o_Count. o_Ready = (state != TWO), taken from a register.
  - EMPTY, fin: main <= in, go to ONE.
  - ONE, fin & fout: main <= in, stay in ONE (back-to-back throughput of 1 per cycle).
  - ONE, fin only: skid <= in, go to TWO.
  - ONE, fout only: go to EMPTY.
  - TWO, fout: main <= skid, go to ONE. No fin is possible in TWO.
  - Otherwise: hold.
- SKID=0:
  - Single register; o_Ready = ~o_Valid | i_Ready.
  - fin loads main.
  - fout without fin empties the stage.
- Head and ordering:
  - o_Data and o_Ctrl always come from main; o_Ctrl is ANDed with o_Valid.
  - Entries are never reordered, duplicated or lost, except on CLR/Reset.
- Latency: 1 cycle from fin to o_Valid when the stage is empty; there is no combinational path from i_Data to o_Data.
- Compatibility:
  - With i_Valid=1 and i_Ready=1 tied high, the stage behaves as a legacy stage register: o_Data is i_Data delayed by 1 cycle.
  - Legacy mapping: WE_n=1 holds, and CLR inserts a bubble with all control bits zero.
- Mid-operation: Reset or CLR while in TWO drops both entries; the stage accepts new input the next cycle.

Test Plan:
1. Reset=1 for 2 cycles with i_Valid=1, i_Ctrl='hFF → o_Valid=0, o_Ctrl=0, o_Data=0, o_Count=0. After release, o_Ready=1.
2. Stream 0x11,0x22,0x33 with i_Ready=1 → o_Data shows 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after fin. o_Count stays 1.
3. Send 0xA1, 0xA2 while i_Ready=0 → o_Count=2, o_Ready=0, head=0xA1. Then i_Ready=1 → outputs 0xA1 then 0xA2, o_Count goes 1 then 0, with no loss.
4. In state TWO assert CLR=1 with WE_n=1, i_Valid=1 → next cycle o_Count=0, o_Valid=0, o_Ctrl=0, o_Ready=1; the input word is not captured.
5. Hold 0x5A (ctrl 'h3) and set WE_n=1 for 3 cycles with i_Valid=1 → o_Valid=0, o_Ctrl=0, o_Ready=0, state unchanged. After WE_n=0, o_Data=0x5A and o_Ctrl='h3 are presented first.
6. SKID=0 instance, i_Ready toggling 1,0,1 with a continuous stream → o_Ready tracks ~o_Valid|i_Ready combinationally; the output sequence is complete and in order.
